// File: rtl/mac_slice_scheduler.sv
// Round-robin scheduler sharing one serial byte-slice MAC among NREQ requesters.
// One operation in flight: grant, issue NSLICE slices MSB first, drain MAC latency, respond.
module mac_slice_scheduler #(
  parameter int NREQ       = 4,
  parameter int ATTR_WIDTH = 24,
  parameter int COEF_WIDTH = 24,
  parameter int SLICE      = 8,
  parameter int ACC_WIDTH  = 20,
  parameter int MAC_LAT    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid_i,
  output logic [NREQ-1:0]            req_ready_o,
  input  logic [NREQ*ATTR_WIDTH-1:0] req_attr_i,
  input  logic [NREQ*COEF_WIDTH-1:0] req_coef_i,
  output logic [SLICE-1:0]           mac_a_o,
  output logic [SLICE-1:0]           mac_b_o,
  output logic                       mac_en_o,
  output logic                       mac_clr_o,
  input  logic [ACC_WIDTH-1:0]       mac_acc_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [ACC_WIDTH-1:0]       rsp_data_o,
  output logic [$clog2(NREQ)-1:0]    rsp_id_o,
  output logic                       busy_o
);
  localparam int NSLICE = ATTR_WIDTH / SLICE;
  localparam int IDW    = $clog2(NREQ);
  localparam int CW     = $clog2(NSLICE + MAC_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

  state_t                state_q, state_d;
  logic [IDW-1:0]        rr_q, rr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ATTR_WIDTH-1:0] attr_q, attr_d;
  logic [COEF_WIDTH-1:0] coef_q, coef_d;
  logic [IDW-1:0]        id_q, id_d;
  logic [ACC_WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic [IDW-1:0]        rsp_id_q, rsp_id_d;

  logic                  gnt_vld;
  logic [IDW-1:0]        gnt_id;
  logic [IDW-1:0]        idx;

  // Scan downward in offset so the nearest set bit at or after rr_q wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      idx = rr_q + IDW'(i);
      if (req_valid_i[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    attr_d      = attr_q;
    coef_d      = coef_q;
    id_d        = id_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    req_ready_o = '0;
    mac_a_o     = '0;
    mac_b_o     = '0;
    mac_en_o    = 1'b0;
    mac_clr_o   = 1'b0;
    case (state_q)
      IDLE: begin
        // Reset wins over the grant handshake in the same cycle.
        if (gnt_vld && !rst) begin
          req_ready_o[gnt_id] = 1'b1;
          attr_d  = req_attr_i[gnt_id*ATTR_WIDTH +: ATTR_WIDTH];
          coef_d  = req_coef_i[gnt_id*COEF_WIDTH +: COEF_WIDTH];
          id_d    = gnt_id;
          rr_d    = gnt_id + IDW'(1);
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mac_a_o   = attr_q[(NSLICE-1-int'(cnt_q))*SLICE +: SLICE];
        mac_b_o   = coef_q[(NSLICE-1-int'(cnt_q))*SLICE +: SLICE];
        mac_en_o  = 1'b1;
        mac_clr_o = (cnt_q == '0);
        if (cnt_q == CW'(NSLICE-1)) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == CW'(MAC_LAT-1)) begin
          rsp_data_d = mac_acc_i;
          rsp_id_d   = id_q;
          cnt_d      = '0;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      cnt_q      <= '0;
      attr_q     <= '0;
      coef_q     <= '0;
      id_q       <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      attr_q     <= attr_d;
      coef_q     <= coef_d;
      id_q       <= id_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  assign rsp_valid_o = (state_q == RESP);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_id_o    = rsp_id_q;
  assign busy_o      = (state_q != IDLE);
endmodule
